// File: rtl/lcd_field_writer_pkg.sv
// Shared definitions for the LCD field writer: HD44780 command bytes,
// FSM state encodings and the 6-bit code to ASCII character map.
package lcd_field_writer_pkg;

  localparam logic [7:0] CMD_FUNC_SET  = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;  // display on, no cursor, no blink
  localparam logic [7:0] CMD_ENTRY     = 8'h06;  // increment, no shift
  localparam logic [7:0] CMD_CLEAR     = 8'h01;  // clear display (slow command)
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;  // OR'd with the DDRAM address

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_ADDR,
    ST_CHAR1,
    ST_CHAR2
  } state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SETUP,
    TX_PULSE,
    TX_WAIT
  } tx_state_t;

  // Formatter code -> LCD character.
  function automatic logic [7:0] code_to_ascii(input logic [5:0] code);
    logic [7:0] ch;
    ch = 8'h20;
    case (code[5:4])
      2'b10:   ch = 8'h30 + {4'h0, code[3:0]};
      2'b01:   ch = 8'h41 + {4'h0, code[3:0]};
      2'b11:   ch = 8'h2D;
      default: ch = 8'h20;
    endcase
    return ch;
  endfunction

  // Power-up init command ROM, sent in index order.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    cmd = CMD_FUNC_SET;
    case (idx)
      2'd0:    cmd = CMD_FUNC_SET;
      2'd1:    cmd = CMD_DISP_ON;
      2'd2:    cmd = CMD_ENTRY;
      default: cmd = CMD_CLEAR;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_field_writer_byte_tx.sv
// lcd_byte_tx: moves one byte onto the HD44780 bus.
// Sequence per byte: RS/DATA set with E low (T_SETUP cycles), E high
// (T_EPULSE cycles), E low with RS/DATA held (T_CMD, or T_CLR when
// long_wait), with done asserted on the final wait cycle.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 accept rs/data/long_wait (only honoured when idle)
//   rs, data, long_wait   byte to send and whether it needs the long wait
//   lcd_rs, lcd_e, lcd_data   registered LCD pins
//   done                  one-cycle pulse on the last wait cycle
module lcd_byte_tx
  import lcd_field_writer_pkg::*;
#(
  parameter int T_SETUP  = 10,
  parameter int T_EPULSE = 50,
  parameter int T_CMD    = 5_000,
  parameter int T_CLR    = 200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       done
);

  localparam int MAX_A = (T_SETUP > T_EPULSE) ? T_SETUP : T_EPULSE;
  localparam int MAX_B = (T_CMD > T_CLR) ? T_CMD : T_CLR;
  localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_T + 1);

  tx_state_t     st;
  logic [CW-1:0] cnt;
  logic          long_q;

  // RS/DATA only load in TX_IDLE, so they cannot move while E is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= TX_IDLE;
      cnt      <= '0;
      long_q   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_data <= 8'h00;
    end else begin
      case (st)
        TX_IDLE: begin
          if (start) begin
            lcd_rs   <= rs;
            lcd_data <= data;
            long_q   <= long_wait;
            cnt      <= CW'(T_SETUP - 1);
            st       <= TX_SETUP;
          end
        end
        TX_SETUP: begin
          if (cnt == '0) begin
            lcd_e <= 1'b1;
            cnt   <= CW'(T_EPULSE - 1);
            st    <= TX_PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        TX_PULSE: begin
          if (cnt == '0) begin
            lcd_e <= 1'b0;
            cnt   <= long_q ? CW'(T_CLR - 1) : CW'(T_CMD - 1);
            st    <= TX_WAIT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        TX_WAIT: begin
          if (cnt == '0) st <= TX_IDLE;
          else           cnt <= cnt - 1'b1;
        end
        default: st <= TX_IDLE;
      endcase
    end
  end

  assign done = (st == TX_WAIT) && (cnt == '0);

endmodule

// File: rtl/lcd_field_writer.sv
// lcd_field_writer: HD44780 power-up init in 8-bit mode, then keeps a
// two-character field at DDRAM address POS in sync with two 6-bit codes.
// The field is rewritten when either code differs from what was last
// written, or on a refresh request.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_char_1/2        6-bit character codes
//   i_refresh         one-cycle rewrite request
//   lcd_rs/rw/e/data  LCD pins (rw tied low, write-only)
//   o_busy            high during init and field writes
//   o_init_done       high once init has finished
module lcd_field_writer
  import lcd_field_writer_pkg::*;
#(
  parameter logic [6:0] POS      = 7'h0E,
  parameter int         T_PWRUP  = 4_000_000,
  parameter int         T_SETUP  = 10,
  parameter int         T_EPULSE = 50,
  parameter int         T_CMD    = 5_000,
  parameter int         T_CLR    = 200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] i_char_1,
  input  logic [5:0] i_char_2,
  input  logic       i_refresh,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       o_busy,
  output logic       o_init_done
);

  localparam int PW = $clog2(T_PWRUP + 1);

  state_t        state;
  logic [PW-1:0] pwr_cnt;
  logic [1:0]    rom_idx;
  logic          sent;       // byte for the current state already handed to tx
  logic          start;
  logic          tx_rs;
  logic [7:0]    tx_data;
  logic          tx_long;
  logic          done;
  logic [5:0]    snap_1, snap_2;
  logic [5:0]    last_1, last_2;
  logic          dirty;

  logic          sending;
  logic          cur_rs;
  logic [7:0]    cur_byte;

  // Byte owed by the current state.
  always_comb begin
    sending  = 1'b0;
    cur_rs   = 1'b0;
    cur_byte = 8'h00;
    case (state)
      ST_INIT:  begin sending = 1'b1; cur_byte = init_cmd(rom_idx); end
      ST_ADDR:  begin sending = 1'b1; cur_byte = CMD_SET_DDRAM | {1'b0, POS}; end
      ST_CHAR1: begin sending = 1'b1; cur_rs = 1'b1; cur_byte = code_to_ascii(snap_1); end
      ST_CHAR2: begin sending = 1'b1; cur_rs = 1'b1; cur_byte = code_to_ascii(snap_2); end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_PWRUP;
      pwr_cnt     <= '0;
      rom_idx     <= 2'd0;
      sent        <= 1'b0;
      start       <= 1'b0;
      tx_rs       <= 1'b0;
      tx_data     <= 8'h00;
      tx_long     <= 1'b0;
      snap_1      <= 6'h00;
      snap_2      <= 6'h00;
      last_1      <= 6'h00;
      last_2      <= 6'h00;
      dirty       <= 1'b1;
      o_busy      <= 1'b1;
      o_init_done <= 1'b0;
    end else begin
      start <= 1'b0;

      // Refresh outside IDLE is remembered; repeated pulses collapse here.
      if (i_refresh && state != ST_IDLE) dirty <= 1'b1;

      // Hand the state's byte to tx once; tx is idle whenever sent is clear.
      if (sending && !sent) begin
        start   <= 1'b1;
        sent    <= 1'b1;
        tx_rs   <= cur_rs;
        tx_data <= cur_byte;
        tx_long <= !cur_rs && (cur_byte == CMD_CLEAR);
      end

      case (state)
        ST_PWRUP: begin
          if (pwr_cnt == PW'(T_PWRUP - 1)) state <= ST_INIT;
          else                             pwr_cnt <= pwr_cnt + 1'b1;
        end
        ST_INIT: begin
          if (sent && done) begin
            sent <= 1'b0;
            if (rom_idx == 2'd3) begin
              o_init_done <= 1'b1;
              o_busy      <= 1'b0;
              state       <= ST_IDLE;
            end else begin
              rom_idx <= rom_idx + 1'b1;
            end
          end
        end
        ST_IDLE: begin
          if (dirty || i_refresh || i_char_1 != last_1 || i_char_2 != last_2) begin
            snap_1 <= i_char_1;
            snap_2 <= i_char_2;
            dirty  <= 1'b0;
            o_busy <= 1'b1;
            state  <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (sent && done) begin
            sent  <= 1'b0;
            state <= ST_CHAR1;
          end
        end
        ST_CHAR1: begin
          if (sent && done) begin
            sent  <= 1'b0;
            state <= ST_CHAR2;
          end
        end
        ST_CHAR2: begin
          if (sent && done) begin
            sent   <= 1'b0;
            last_1 <= snap_1;
            last_2 <= snap_2;
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_PWRUP;
      endcase
    end
  end

  lcd_byte_tx #(
    .T_SETUP (T_SETUP),
    .T_EPULSE(T_EPULSE),
    .T_CMD   (T_CMD),
    .T_CLR   (T_CLR)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rs       (tx_rs),
    .data     (tx_data),
    .long_wait(tx_long),
    .lcd_rs   (lcd_rs),
    .lcd_e    (lcd_e),
    .lcd_data (lcd_data),
    .done     (done)
  );

  assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_field_writer.sv
// Testbench for lcd_field_writer with shortened timing.
module tb_lcd_field_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] i_char_1, i_char_2;
  logic       i_refresh;
  logic       lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data;
  logic       o_busy, o_init_done;

  int checks = 0;
  int errors = 0;

  lcd_field_writer #(
    .POS(7'h0E), .T_PWRUP(20), .T_SETUP(1), .T_EPULSE(2), .T_CMD(4), .T_CLR(8)
  ) dut (
    .clk(clk), .rst(rst), .i_char_1(i_char_1), .i_char_2(i_char_2),
    .i_refresh(i_refresh), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_data(lcd_data), .o_busy(o_busy), .o_init_done(o_init_done)
  );

  always #5 clk = ~clk;

  // Bus monitor: sampled 2 time units after each rising edge.
  logic [8:0] q[$];          // {rs, data} latched on each E fall
  int cyc = 0, rises = 0, busy_cnt = 0, viol = 0;
  int first_rise = -1, last_fall = 0, done_gap = -1;
  logic prev_e = 1'b0, prev_rs = 1'b0, prev_done = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge clk) begin
    #2;
    cyc++;
    if (lcd_e && !prev_e) begin
      rises++;
      if (first_rise < 0) first_rise = cyc;
      if (lcd_rs !== prev_rs || lcd_data !== prev_data) viol++;
    end
    if (lcd_e && prev_e && (lcd_rs !== prev_rs || lcd_data !== prev_data)) viol++;
    if (!lcd_e && prev_e) begin
      last_fall = cyc;
      q.push_back({lcd_rs, lcd_data});
    end
    if (o_init_done && !prev_done) done_gap = cyc - last_fall;
    if (o_busy) busy_cnt++;
    prev_e = lcd_e; prev_rs = lcd_rs; prev_data = lcd_data; prev_done = o_init_done;
  end

  task automatic chk_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_byte(input string name, input int idx, input logic [8:0] exp);
    checks++;
    if (idx >= q.size()) begin
      errors++;
      $display("FAIL %s: byte %0d missing (only %0d latched), want rs=%0d data=%h",
               name, idx, q.size(), exp[8], exp[7:0]);
    end else if (q[idx] !== exp) begin
      errors++;
      $display("FAIL %s: byte %0d got rs=%0d data=%h want rs=%0d data=%h",
               name, idx, q[idx][8], q[idx][7:0], exp[8], exp[7:0]);
    end
  endtask

  // Wait until o_busy has stayed low for 4 samples.
  task automatic wait_quiet(input string name, input int budget);
    int low = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      low = o_busy ? 0 : low + 1;
      if (low >= 4) return;
    end
    checks++; errors++;
    $display("FAIL %s: o_busy still high after %0d cycles", name, budget);
  endtask

  task automatic wait_rises(input string name, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rises >= target) return;
    end
    checks++; errors++;
    $display("FAIL %s: E rise count %0d never reached %0d", name, rises, target);
  endtask

  task automatic pulse_refresh();
    i_refresh = 1'b1;
    @(negedge clk);
    i_refresh = 1'b0;
  endtask

  typedef struct {
    logic [5:0] c1, c2;
    logic       refresh;
    logic [7:0] e1, e2;
  } vec_t;
  vec_t vt[5];

  initial begin
    int rel, r0, b0;
    vt[0] = '{6'b000101, 6'b011111, 1'b1, 8'h20, 8'h50};
    vt[1] = '{6'b110000, 6'b100000, 1'b0, 8'h2D, 8'h30};
    vt[2] = '{6'b110000, 6'b100000, 1'b1, 8'h2D, 8'h30};  // unchanged, refresh only
    vt[3] = '{6'b011010, 6'b101001, 1'b0, 8'h4B, 8'h39};
    vt[4] = '{6'b001111, 6'b111111, 1'b1, 8'h20, 8'h2D};

    rst = 1'b1; i_char_1 = 6'h00; i_char_2 = 6'h00; i_refresh = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk_val("rst_lcd_e", int'(lcd_e), 0);
    chk_val("rst_lcd_rs", int'(lcd_rs), 0);
    chk_val("rst_lcd_rw", int'(lcd_rw), 0);
    chk_val("rst_lcd_data", int'(lcd_data), 0);
    chk_val("rst_busy", int'(o_busy), 1);
    chk_val("rst_init_done", int'(o_init_done), 0);

    // 1. Init sequence, then the dirty write of codes 0/0
    q.delete();
    rel = cyc;
    rst = 1'b0;
    wait_quiet("init", 600);
    checks++;
    if (first_rise - rel <= 20) begin
      errors++;
      $display("FAIL init_first_e: first E rise at cycle %0d, want after 20", first_rise - rel);
    end
    chk_val("init_done_gap", done_gap, 8);
    chk_val("init_done_level", int'(o_init_done), 1);
    chk_byte("init_38", 0, {1'b0, 8'h38});
    chk_byte("init_0c", 1, {1'b0, 8'h0C});
    chk_byte("init_06", 2, {1'b0, 8'h06});
    chk_byte("init_01", 3, {1'b0, 8'h01});
    chk_byte("dirty_addr", 4, {1'b0, 8'h8E});
    chk_byte("dirty_c1", 5, {1'b1, 8'h20});
    chk_byte("dirty_c2", 6, {1'b1, 8'h20});
    chk_val("init_count", q.size(), 7);

    // 2. Code change -> field write
    q.delete();
    i_char_1 = 6'b100011; i_char_2 = 6'b100010;
    wait_quiet("write", 300);
    chk_byte("write_addr", 0, {1'b0, 8'h8E});
    chk_byte("write_c1", 1, {1'b1, 8'h33});
    chk_byte("write_c2", 2, {1'b1, 8'h32});
    chk_val("write_count", q.size(), 3);

    // 3. Stable codes -> no activity
    r0 = rises; b0 = busy_cnt;
    repeat (200) @(negedge clk);
    chk_val("stable_e_pulses", rises - r0, 0);
    chk_val("stable_busy_cycles", busy_cnt - b0, 0);

    // 4. i_char_2 changes during CHAR1 -> snapshot write, then a second write
    q.delete();
    r0 = rises;
    pulse_refresh();
    wait_rises("midchg_char1", r0 + 2, 200);
    i_char_2 = 6'b100001;
    wait_quiet("midchg", 400);
    chk_byte("midchg_addr_a", 0, {1'b0, 8'h8E});
    chk_byte("midchg_c1_a", 1, {1'b1, 8'h33});
    chk_byte("midchg_c2_a", 2, {1'b1, 8'h32});
    chk_byte("midchg_addr_b", 3, {1'b0, 8'h8E});
    chk_byte("midchg_c1_b", 4, {1'b1, 8'h33});
    chk_byte("midchg_c2_b", 5, {1'b1, 8'h31});
    chk_val("midchg_count", q.size(), 6);

    // 6. Mapping table
    foreach (vt[i]) begin
      q.delete();
      i_char_1 = vt[i].c1; i_char_2 = vt[i].c2;
      if (vt[i].refresh) pulse_refresh();
      wait_quiet("map", 300);
      chk_byte($sformatf("map%0d_addr", i), 0, {1'b0, 8'h8E});
      chk_byte($sformatf("map%0d_c1", i), 1, {1'b1, vt[i].e1});
      chk_byte($sformatf("map%0d_c2", i), 2, {1'b1, vt[i].e2});
      chk_val($sformatf("map%0d_count", i), q.size(), 3);
    end

    // Several refresh pulses during a write collapse into one rewrite
    q.delete();
    r0 = rises;
    pulse_refresh();
    wait_rises("collapse_start", r0 + 1, 200);
    pulse_refresh();
    repeat (3) @(negedge clk);
    pulse_refresh();
    wait_quiet("collapse", 400);
    chk_val("collapse_count", q.size(), 6);
    chk_byte("collapse_addr_b", 3, {1'b0, 8'h8E});

    // 5. Reset while E is high -> clean restart from 0x38
    i_char_1 = 6'b100111; i_char_2 = 6'b010000;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        if (lcd_e) seen = 1'b1;
      end
      chk_val("rst_mid_e_seen", int'(seen), 1);
    end
    rst = 1'b1;
    @(negedge clk);
    chk_val("rst_mid_lcd_e", int'(lcd_e), 0);
    chk_val("rst_mid_init_done", int'(o_init_done), 0);
    chk_val("rst_mid_busy", int'(o_busy), 1);
    @(negedge clk);
    q.delete();
    rst = 1'b0;
    wait_quiet("reinit", 600);
    chk_byte("reinit_38", 0, {1'b0, 8'h38});
    chk_byte("reinit_0c", 1, {1'b0, 8'h0C});
    chk_byte("reinit_06", 2, {1'b0, 8'h06});
    chk_byte("reinit_01", 3, {1'b0, 8'h01});
    chk_byte("reinit_addr", 4, {1'b0, 8'h8E});
    chk_byte("reinit_c1", 5, {1'b1, 8'h37});
    chk_byte("reinit_c2", 6, {1'b1, 8'h41});
    chk_val("reinit_count", q.size(), 7);

    // Bus discipline over the whole run
    chk_val("bus_stable_while_e", viol, 0);
    chk_val("lcd_rw_low", int'(lcd_rw), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
